// File: rtl/trivium_pkg.sv
// trivium_pkg: Trivium geometry, tap positions, FSM states and key/IV state loader.
// State bit s_i (1-based, as in the cipher description) lives at vector index i-1.
package trivium_pkg;

    localparam int STATE_W    = 288;
    localparam int INIT_STEPS = 1152;

    localparam int S66  = 66;
    localparam int S93  = 93;
    localparam int S91  = 91;
    localparam int S92  = 92;
    localparam int S171 = 171;
    localparam int S162 = 162;
    localparam int S177 = 177;
    localparam int S175 = 175;
    localparam int S176 = 176;
    localparam int S264 = 264;
    localparam int S243 = 243;
    localparam int S288 = 288;
    localparam int S286 = 286;
    localparam int S287 = 287;
    localparam int S69  = 69;

    typedef enum logic [1:0] {IDLE, INIT, RUN} state_e;

    function automatic logic tap(input logic [STATE_W-1:0] s, input int n);
        return s[n-1];
    endfunction

    // K1 = key[79] lands in s1, IV1 = iv[79] in s94; s286..s288 preset to 1.
    function automatic logic [STATE_W-1:0] trivium_load(input logic [79:0] key, input logic [79:0] iv);
        logic [STATE_W-1:0] s;
        s = '0;
        for (int i = 0; i < 80; i++) begin
            s[i]      = key[79-i];
            s[93 + i] = iv[79-i];
        end
        s[287:285] = 3'b111;
        return s;
    endfunction

endpackage

// File: rtl/trivium_round.sv
// trivium_round: W Trivium steps unrolled combinationally; first step's keystream bit lands in z[W-1].
module trivium_round
    import trivium_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [STATE_W-1:0] s_i,
    output logic [STATE_W-1:0] s_o,
    output logic [W-1:0]       z
);

    logic [STATE_W-1:0] s;
    logic t1, t2, t3;

    always_comb begin
        s  = s_i;
        z  = '0;
        t1 = 1'b0;
        t2 = 1'b0;
        t3 = 1'b0;
        for (int i = 0; i < W; i++) begin
            t1 = tap(s, S66) ^ tap(s, S93);
            t2 = tap(s, S162) ^ tap(s, S177);
            t3 = tap(s, S243) ^ tap(s, S288);
            z[W-1-i] = t1 ^ t2 ^ t3;
            t1 = t1 ^ (tap(s, S91) & tap(s, S92)) ^ tap(s, S171);
            t2 = t2 ^ (tap(s, S175) & tap(s, S176)) ^ tap(s, S264);
            t3 = t3 ^ (tap(s, S286) & tap(s, S287)) ^ tap(s, S69);
            // three register shifts: t3 -> s1, t1 -> s94, t2 -> s178
            s = {s[286:177], t2, s[175:93], t1, s[91:0], t3};
        end
        s_o = s;
    end

endmodule

// File: rtl/trivium_stream.sv
// trivium_stream: handshaked Trivium XOR engine, W keystream bits per accepted word.
// The cipher state only advances in INIT and on accepted words, so stalls never skip keystream.
module trivium_stream
    import trivium_pkg::*;
#(
    parameter int W     = 8,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [79:0]      key,
    input  logic [79:0]      iv,
    input  logic [LEN_W-1:0] len,
    input  logic [W-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    localparam int INIT_CYC = INIT_STEPS / W;
    localparam int IC_W     = $clog2(INIT_CYC + 1);

    if (!(W inside {1, 2, 4, 8, 16, 32, 64})) begin : g_bad_w
        $error("trivium_stream: W must be one of 1, 2, 4, 8, 16, 32, 64");
    end

    state_e             state_q, state_d;
    logic [STATE_W-1:0] st_q, st_d, st_nxt;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [IC_W-1:0]    ic_q, ic_d;
    logic [W-1:0]       out_data_q, out_data_d, z;
    logic               out_valid_q, out_valid_d, done_q, done_d;
    logic               accept, drain;

    trivium_round #(.W(W)) u_round (
        .s_i (st_q),
        .s_o (st_nxt),
        .z   (z)
    );

    assign in_ready  = (state_q == RUN) && (cnt_q != '0) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid_q && out_ready;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = state_q != IDLE;
    assign done      = done_q;

    always_comb begin
        state_d     = state_q;
        st_d        = st_q;
        cnt_d       = cnt_q;
        ic_d        = ic_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = INIT;
                st_d    = trivium_load(key, iv);
                cnt_d   = len;
                ic_d    = IC_W'(INIT_CYC);
            end
            INIT: begin
                st_d = st_nxt;
                ic_d = ic_q - 1'b1;
                if (ic_q == IC_W'(1)) begin
                    state_d = (cnt_q == '0) ? IDLE : RUN;
                    done_d  = cnt_q == '0;
                end
            end
            RUN: begin
                if (drain) out_valid_d = 1'b0;
                if (accept) begin
                    out_data_d  = in_data ^ z;
                    out_valid_d = 1'b1;
                    st_d        = st_nxt;
                    cnt_d       = cnt_q - 1'b1;
                end
                if (drain && cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            st_q        <= '0;
            cnt_q       <= '0;
            ic_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            ic_q        <= ic_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_trivium_stream.sv
// tb_trivium_stream: scoreboard bench for trivium_stream (W=8) against a bit-serial Trivium model.
module tb_trivium_stream;

    localparam int W = 8;
    localparam int N = 1152 / W;

    logic           clk = 1'b0, reset = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [79:0]    key = '0, iv = '0;
    logic [15:0]    len = '0;
    logic [W-1:0]   in_data = '0;
    logic           in_ready, out_valid, busy, done;
    logic [W-1:0]   out_data;
    int             checks = 0, errors = 0;
    bit   [288:1]   ms;
    logic [W-1:0]   src_q[$], ref_q[$], exp_q[$], got_q[$];

    always #5 clk = ~clk;

    trivium_stream #(.W(W), .LEN_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .key       (key),
        .iv        (iv),
        .len       (len),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void mload(input logic [79:0] k, input logic [79:0] v);
        ms = '0;
        for (int i = 1; i <= 80; i++) begin
            ms[i]      = k[80-i];
            ms[93 + i] = v[80-i];
        end
        ms[286] = 1'b1;
        ms[287] = 1'b1;
        ms[288] = 1'b1;
    endfunction

    function automatic bit mstep();
        bit t1, t2, t3, zb;
        t1 = ms[66] ^ ms[93];
        t2 = ms[162] ^ ms[177];
        t3 = ms[243] ^ ms[288];
        zb = t1 ^ t2 ^ t3;
        t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
        t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
        t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
        for (int i = 288; i > 178; i--) ms[i] = ms[i-1];
        ms[178] = t2;
        for (int i = 177; i > 94; i--) ms[i] = ms[i-1];
        ms[94] = t1;
        for (int i = 93; i > 1; i--) ms[i] = ms[i-1];
        ms[1] = t3;
        return zb;
    endfunction

    function automatic logic [W-1:0] mword();
        logic [W-1:0] w;
        for (int b = 0; b < W; b++) w[W-1-b] = mstep();
        return w;
    endfunction

    task automatic fill_random(input int n);
        src_q.delete();
        repeat (n) src_q.push_back(W'($urandom));
    endtask

    task automatic fill_zero(input int n);
        src_q.delete();
        repeat (n) src_q.push_back('0);
    endtask

    // One full transaction: start, stream n words, check data, handshake rules and timing.
    task automatic run(input int n, input bit bp, input bit use_model, input int abort, input bit poke);
        int cyc, sent, first_rdy, done_cyc, done_cnt, limit;
        logic [79:0] k0;
        logic [W-1:0] e;
        cyc = 1; sent = 0; first_rdy = -1; done_cyc = -1; done_cnt = 0;
        limit = N + 8 * n + 20;
        k0 = key;
        mload(key, iv);
        for (int i = 0; i < 1152; i++) void'(mstep());
        exp_q.delete();
        got_q.delete();
        @(negedge clk);
        start = 1'b1;
        len = 16'(n);
        @(negedge clk);
        start = 1'b0;
        while (cyc <= limit && (done_cyc < 0 || cyc <= done_cyc + 2)) begin
            if (abort > 0 && sent == abort) begin
                reset = 1'b1;
                #1;
                check("rst_out_valid", 64'(out_valid), 64'(0));
                check("rst_out_data", 64'(out_data), 64'(0));
                check("rst_in_ready", 64'(in_ready), 64'(0));
                check("rst_busy", 64'(busy), 64'(0));
                check("rst_done", 64'(done), 64'(0));
                in_valid = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            start = poke && cyc == N + 6;
            key = (poke && cyc == N + 6) ? ~k0 : k0;
            len = (poke && cyc == N + 6) ? 16'd5 : 16'(n);
            in_valid = sent < n && (!bp || $urandom_range(3) != 0);
            in_data = in_valid ? src_q[sent] : '0;
            out_ready = !bp || $urandom_range(1) == 1;
            #1;
            if (cyc == 1) check("busy_after_start", 64'(busy), 64'(1));
            if (in_ready && first_rdy < 0) first_rdy = cyc;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_at_done", 64'(busy), 64'(0));
            end
            if (out_valid && !out_ready) check("stall_in_ready", 64'(in_ready), 64'(0));
            if (in_valid && in_ready) begin
                e = use_model ? (in_data ^ mword()) : ref_q.pop_front();
                exp_q.push_back(e);
                sent++;
            end
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                if (exp_q.size() == 0) check("spurious_out", 64'(exp_q.size()), 64'(1));
                else check("out_data", 64'(out_data), 64'(exp_q.pop_front()));
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        in_valid = 1'b0;
        key = k0;
        check("done_count", 64'(done_cnt), 64'(1));
        check("words_sent", 64'(sent), 64'(n));
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        check("first_in_ready", 64'(first_rdy), 64'(n > 0 ? N + 1 : -1));
        if (!bp) check("done_cycle", 64'(done_cyc), 64'(n > 0 ? N + n + 2 : N + 1));
    endtask

    initial begin
        logic [W-1:0] pt_q[$];
        #1;
        check("reset_in_ready", 64'(in_ready), 64'(0));
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_out_data", 64'(out_data), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        @(negedge clk);
        reset = 1'b0;

        key = 80'h80000000000000000000;
        iv  = '0;
        fill_zero(64);
        run(64, 1'b0, 1'b1, 0, 1'b0);

        key = 80'h0123456789abcdef0f1e;
        iv  = 80'hfedcba98765432100a5c;
        fill_random(32);
        run(32, 1'b1, 1'b1, 0, 1'b0);

        run(0, 1'b0, 1'b1, 0, 1'b0);
        check("len0_no_out", 64'(got_q.size()), 64'(0));

        fill_random(20);
        run(20, 1'b0, 1'b1, 0, 1'b1);

        fill_random(40);
        pt_q = src_q;
        run(40, 1'b1, 1'b1, 0, 1'b0);
        ref_q = pt_q;
        src_q = got_q;
        run(40, 1'b1, 1'b0, 0, 1'b0);

        key = 80'h80000000000000000000;
        iv  = '0;
        fill_zero(16);
        run(16, 1'b0, 1'b1, 10, 1'b0);
        #1;
        check("post_reset_busy", 64'(busy), 64'(0));
        check("post_reset_out_valid", 64'(out_valid), 64'(0));
        run(16, 1'b0, 1'b1, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trivium_stream.md
# trivium_stream

Parametrised Trivium stream-cipher engine that generalises the fixed-length, 1-bit-per-cycle encryptor. It computes W keystream bits per clock, selectable by parameter, and XORs them onto a handshaked data stream of programmable length instead of producing one wide output bus. It sits between a data source and sink as the encrypt/decrypt datapath; the same operation serves both directions.

## Interface
- `W`, default 8: bits processed per cycle; legal values 1, 2, 4, 8, 16, 32, 64. Other values are an elaboration error.
- `LEN_W`, default 16: width of the word-count input.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `start`  in  1: one-cycle request; sampled only in IDLE.
- `key`  in  80: key; K1 = key[79] … K80 = key[0]; sampled with start.
- `iv`  in  80: IV; IV1 = iv[79] … IV80 = iv[0]; sampled with start.
- `len`  in  LEN_W: number of W-bit words to process; sampled with start.
- `in_data`  in  W: plaintext/ciphertext word.
- `in_valid`  in  1: in_data valid.
- `in_ready`  out  1: engine accepts in_data this cycle.
- `out_data`  out  W: in_data XOR keystream, registered.
- `out_valid`  out  1: out_data valid.
- `out_ready`  in  1: sink accepts out_data.
- `busy`  out  1: high in INIT and RUN.
- `done`  out  1: one-cycle pulse after the last word is accepted by the sink, or after INIT when len = 0.

## Operation
- States: IDLE, INIT, RUN.
- IDLE, start=1: the 288-bit state is loaded as follows:
  - s1..s80 = K1..K80; s81..s93 = 0.
  - s94..s173 = IV1..IV80; s174..s177 = 0.
  - s178..s285 = 0; s286..s288 = 1.
  - The word counter is set to len, an init counter to 1152/W, and the state moves to INIT.
- Trivium step:
  - t1=s66^s93, t2=s162^s177, t3=s243^s288, z=t1^t2^t3.
  - t1^=s91&s92^s171, t2^=s175&s176^s264, t3^=s286&s287^s69.
  - Shift (t3,s1..s92), (t1,s94..s176), (t2,s178..s287).
- INIT: W steps per cycle, z discarded. When the init counter reaches 0, go to RUN, or to IDLE with a done pulse if len = 0.
- RUN:
  - in_ready = !out_valid || out_ready.
  - On in_valid && in_ready: out_data ← in_data ^ z_word, out_valid ← 1, advance W steps, decrement the word counter.
  - The cipher state advances only on an accepted word. Backpressure never drops or repeats keystream.
- z_word ordering: the first step's bit goes to out_data[W-1] and the last to out_data[0].
- When the last output word is consumed (out_valid && out_ready with the counter at 0): out_valid ← 0, done pulses, return to IDLE.
- start outside IDLE is ignored; key, iv and len changes outside IDLE have no effect.
- in_ready = 0 in IDLE and INIT, and in RUN once the counter reaches 0.

## Timing
- Reset values: in_ready 0, out_valid 0, out_data 0, busy 0, done 0, state IDLE, 288-bit state 0.
- start accepted at edge k: busy=1 from k+1; INIT lasts 1152/W cycles (1152 for W=1, 144 for W=8, 18 for W=64); in_ready can first be 1 at cycle k+1+1152/W.
- Data latency: one cycle from input acceptance to out_valid. Throughput: one word per cycle with out_ready held high.
- done is asserted in the cycle after the final out handshake, and busy falls in that same cycle.
- Reset asserted mid-operation: outputs clear immediately (asynchronous). Any in-flight word is lost; no done pulse.
- Simultaneous final handshake and new start: start is ignored because the state is not yet IDLE.
- The word counter never wraps below 0.

## Structure
- Package `trivium_pkg` holds:
  - STATE_W=288 and INIT_STEPS=1152;
  - tap constants (66, 93, 91, 92, 171, 162, 177, 175, 176, 264, 243, 288, 286, 287, 69);
  - the state enum {IDLE, INIT, RUN};
  - a `trivium_load(key, iv)` function returning the 288-bit state.
- Sub-module `trivium_round #(W)`: purely combinational W-step unrolled update. Inputs: 288-bit state. Outputs: next 288-bit state and z[W-1:0]. The top level holds the FSM, counters and output register.

## Test plan
- Golden vector, W=1, key=80'h80000000000000000000, iv=0, len=4096, in_data all 0: out_data equals the bit-accurate C reference keystream; done pulses once; total cycles from start = 1 + 1152 + 4096 + 1.
- Width equivalence, same key/IV, W=64, len=64: concatenated out_data equals the 4096-bit W=1 stream bit for bit, and INIT lasts exactly 18 cycles.
- Backpressure, W=8, len=32: random out_ready and in_valid. Output matches the reference ciphertext; no word is duplicated or dropped; in_ready=0 whenever out_valid && !out_ready.
- Round trip, W=16, len=100: ciphertext fed back through a second run with the same key/IV recovers the original plaintext exactly.
- Boundaries:
  - len=0 gives done exactly 1152/W+1 cycles after start, with no out_valid.
  - start pulsed during RUN leaves the state and counter unchanged.
- Reset mid-RUN after 10 words: all outputs are 0 in the same cycle and the FSM returns to IDLE. A fresh start then reproduces the golden stream from word 0.
